cdb_arbiter: RTL

Completion-stage arbiter between the functional units (ALU0, ALU1, MEM) and the common data bus. It buffers finished results per FU in small FIFOs and selects one result per cycle with round-robin priority. It drives a registered CDB packet (tag, value, branch outcome) consumed by the reservation station, ROB and dispatch wakeup logic. A broadcast taken branch flushes all buffered results.

---
 rtl/cdb_arbiter_if.sv | 37 +++
 rtl/cdb_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// Bundle between the functional units and the CDB arbiter: per-FU result
// ports with ready, plus the registered common-data-bus broadcast.
interface cdb_arbiter_if #(
  parameter int NUM_FU = 3,
  parameter int TAG_W  = 5,
  parameter int XLEN   = 32
) ();
  localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic [NUM_FU*XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0]       fu_take_branch;
  logic [NUM_FU*XLEN-1:0]  fu_target;
  logic [NUM_FU-1:0]       fu_ready;

  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [XLEN-1:0]         cdb_value;
  logic                    cdb_take_branch;
  logic [XLEN-1:0]         cdb_target;
  logic [SRC_W-1:0]        cdb_src;

  // Functional-unit / consumer side.
  modport master (
    output fu_valid, fu_tag, fu_value, fu_take_branch, fu_target,
    input  fu_ready,
    input  cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_target, cdb_src
  );

  // Arbiter side.
  modport slave (
    input  fu_valid, fu_tag, fu_value, fu_take_branch, fu_target,
    output fu_ready,
    output cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_target, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Completion-stage arbiter: per-FU result FIFOs drained one entry per cycle
// onto a registered CDB with round-robin priority; a taken branch flushes all.
module cdb_arbiter #(
  parameter int NUM_FU = 3,
  parameter int TAG_W  = 5,
  parameter int XLEN   = 32,
  parameter int DEPTH  = 2
) (
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [SRC_W:0]   NFU  = (SRC_W + 1)'(NUM_FU);
  localparam logic [SRC_W-1:0] LAST = SRC_W'(NUM_FU - 1);

  logic [TAG_W-1:0] tag_mem_q [NUM_FU][DEPTH];
  logic [TAG_W-1:0] tag_mem_d [NUM_FU][DEPTH];
  logic [XLEN-1:0]  val_mem_q [NUM_FU][DEPTH];
  logic [XLEN-1:0]  val_mem_d [NUM_FU][DEPTH];
  logic [XLEN-1:0]  tgt_mem_q [NUM_FU][DEPTH];
  logic [XLEN-1:0]  tgt_mem_d [NUM_FU][DEPTH];
  logic             br_mem_q  [NUM_FU][DEPTH];
  logic             br_mem_d  [NUM_FU][DEPTH];

  logic [PTR_W-1:0] wr_ptr_q [NUM_FU];
  logic [PTR_W-1:0] wr_ptr_d [NUM_FU];
  logic [PTR_W-1:0] rd_ptr_q [NUM_FU];
  logic [PTR_W-1:0] rd_ptr_d [NUM_FU];
  logic [CNT_W-1:0] count_q  [NUM_FU];
  logic [CNT_W-1:0] count_d  [NUM_FU];
  logic [SRC_W-1:0] rr_q, rr_d;

  logic             cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]  cdb_value_q, cdb_value_d;
  logic             cdb_br_q, cdb_br_d;
  logic [XLEN-1:0]  cdb_target_q, cdb_target_d;
  logic [SRC_W-1:0] cdb_src_q, cdb_src_d;

  logic [NUM_FU-1:0] ready, nonempty, push, pop;
  logic              flush, found;
  logic [SRC_W-1:0]  winner;
  logic [SRC_W:0]    scan;

  // The broadcast itself is never suppressed; flushing acts on the next edge.
  assign flush = cdb_valid_q & cdb_br_q;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    assign ready[gi]    = (count_q[gi] != FULL);
    assign nonempty[gi] = (count_q[gi] != '0);
    assign push[gi]     = bus.fu_valid[gi] & ready[gi] & ~flush;
    assign pop[gi]      = found & ~flush & (winner == SRC_W'(gi));
  end

  // Scan from rr_q with an explicit wrap so NUM_FU need not be a power of two.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan = {1'b0, rr_q} + (SRC_W + 1)'(k);
      if (scan >= NFU) scan = scan - NFU;
      if (!found && nonempty[scan[SRC_W-1:0]]) begin
        found  = 1'b1;
        winner = scan[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    tag_mem_d = tag_mem_q;
    val_mem_d = val_mem_q;
    tgt_mem_d = tgt_mem_q;
    br_mem_d  = br_mem_q;
    for (int i = 0; i < NUM_FU; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        count_d[i]  = '0;
      end else begin
        if (push[i]) begin
          tag_mem_d[i][wr_ptr_q[i]] = bus.fu_tag[i*TAG_W +: TAG_W];
          val_mem_d[i][wr_ptr_q[i]] = bus.fu_value[i*XLEN +: XLEN];
          tgt_mem_d[i][wr_ptr_q[i]] = bus.fu_target[i*XLEN +: XLEN];
          br_mem_d[i][wr_ptr_q[i]]  = bus.fu_take_branch[i];
          wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
        end
        if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Payload fields hold when idle; only cdb_valid drops.
  always_comb begin
    cdb_valid_d  = 1'b0;
    cdb_tag_d    = cdb_tag_q;
    cdb_value_d  = cdb_value_q;
    cdb_br_d     = cdb_br_q;
    cdb_target_d = cdb_target_q;
    cdb_src_d    = cdb_src_q;
    rr_d         = rr_q;
    if (flush) begin
      rr_d = '0;
    end else if (found) begin
      cdb_valid_d  = 1'b1;
      cdb_tag_d    = tag_mem_q[winner][rd_ptr_q[winner]];
      cdb_value_d  = val_mem_q[winner][rd_ptr_q[winner]];
      cdb_br_d     = br_mem_q[winner][rd_ptr_q[winner]];
      cdb_target_d = tgt_mem_q[winner][rd_ptr_q[winner]];
      cdb_src_d    = winner;
      rr_d         = (winner == LAST) ? '0 : winner + SRC_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_q         <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_value_q  <= '0;
      cdb_br_q     <= 1'b0;
      cdb_target_q <= '0;
      cdb_src_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rr_q         <= rr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_value_q  <= cdb_value_d;
      cdb_br_q     <= cdb_br_d;
      cdb_target_q <= cdb_target_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  // Storage carries no reset; validity is tracked by the counters alone.
  always_ff @(posedge clock) begin
    tag_mem_q <= tag_mem_d;
    val_mem_q <= val_mem_d;
    tgt_mem_q <= tgt_mem_d;
    br_mem_q  <= br_mem_d;
  end

  assign bus.fu_ready        = ready;
  assign bus.cdb_valid       = cdb_valid_q;
  assign bus.cdb_tag         = cdb_tag_q;
  assign bus.cdb_value       = cdb_value_q;
  assign bus.cdb_take_branch = cdb_br_q;
  assign bus.cdb_target      = cdb_target_q;
  assign bus.cdb_src         = cdb_src_q;
endmodule
